// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CP0 definitions for the writeback/CP0 unit.
// Holds the CP0 register numbers, the exception codes and the bit
// positions of the Status and Cause fields.
package cpu_defs_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_DZ  = 5'd13;

  // Status fields
  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LSB = 8;

  // Cause fields; IP[9:8] are software bits, IP[15:10] follow the interrupt lines
  localparam int CA_EXC_LSB = 2;
  localparam int CA_IP_LSB  = 8;

endpackage

// File: rtl/cp0_regs.sv
// cp0_regs: CP0 state (Count, Compare, Status, Cause, EPC).
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   mtc0_we/addr/data     qualified mtc0 write (already cancelled on exception)
//   raddr / rdata         combinational mfc0 read, pre-edge value
//   exc_take/code/pc      exception commit: ExcCode, EXL and (if EXL=0) EPC
//   eret_take             qualified eret: clears EXL
//   int_i                 external level interrupt lines
//   epc, ie, exl, im, ip  current state for the exception logic
module cp0_regs
  import cpu_defs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_take,
  input  logic [5:0]  int_i,
  output logic [31:0] epc,
  output logic        ie,
  output logic        exl,
  output logic [7:0]  im,
  output logic [7:0]  ip
);

  logic [31:0] count, compare;
  logic [4:0]  code_q;
  logic        timer_pend;
  logic        match;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign match      = (count == compare) && (compare != 32'd0);
  assign wr_count   = mtc0_we && (mtc0_addr == CP0_COUNT);
  assign wr_compare = mtc0_we && (mtc0_addr == CP0_COMPARE);
  assign wr_status  = mtc0_we && (mtc0_addr == CP0_STATUS);
  assign wr_cause   = mtc0_we && (mtc0_addr == CP0_CAUSE);
  assign wr_epc     = mtc0_we && (mtc0_addr == CP0_EPC);

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      epc        <= '0;
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      ip         <= '0;
      code_q     <= '0;
      timer_pend <= 1'b0;
    end else begin
      count      <= wr_count ? mtc0_data : count + 32'd1;
      timer_pend <= wr_compare ? 1'b0 : (timer_pend | match);
      // the match itself feeds IP7 so the timer shows up one cycle after Count==Compare
      ip[7:2]    <= {int_i[5] | timer_pend | match, int_i[4:0]};
      if (wr_compare) compare <= mtc0_data;
      if (wr_cause)   ip[1:0] <= mtc0_data[CA_IP_LSB +: 2];
      if (wr_epc)     epc     <= mtc0_data;
      if (wr_status) begin
        ie  <= mtc0_data[ST_IE];
        exl <= mtc0_data[ST_EXL];
        im  <= mtc0_data[ST_IM_LSB +: 8];
      end
      if (eret_take) exl <= 1'b0;
      if (exc_take) begin
        code_q <= exc_code;
        exl    <= 1'b1;
        if (!exl) epc <= exc_pc;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = {16'h0, im, 6'h0, exl, ie};
      CP0_CAUSE:   rdata = {16'h0, ip, 1'b0, code_q, 2'b0};
      CP0_EPC:     rdata = epc;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_cp0_unit.sv
// wb_cp0_unit: writeback stage with HI/LO and CP0.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   WB_*              MEM/WB pipeline register outputs (control, exception flags, data)
//   mdu_we/hi/lo      multiply/divide result write into HI/LO
//   int_i             external level interrupts
//   rf_we/waddr/wdata register-file write
//   hi_o, lo_o        current HI/LO for forwarding
//   flush, redirect, redirect_pc  combinational pipeline flush and PC redirect
module wb_cp0_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        WB_RegWrite,
  input  logic        WB_MemIOtoReg,
  input  logic        WB_Mfhi,
  input  logic        WB_Mflo,
  input  logic        WB_Mthi,
  input  logic        WB_Mtlo,
  input  logic        WB_Jal,
  input  logic        WB_Jalr,
  input  logic        WB_Bgezal,
  input  logic        WB_Bltzal,
  input  logic        WB_Mfc0,
  input  logic        WB_Mtc0,
  input  logic        WB_Eret,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_instruction,
  input  logic [31:0] WB_opcplus4,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_ALU_Result,
  input  logic [31:0] WB_MemorIOData,
  input  logic [31:0] WB_rt_value,
  input  logic [4:0]  WB_rd,
  input  logic [4:0]  WB_waddr,
  input  logic        mdu_we,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  input  logic [5:0]  int_i,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic        present, link, link31, irq;
  logic        exc_take, eret_take, mtc0_we;
  logic [4:0]  exc_code;
  logic [31:0] hi_q, lo_q, cp0_rdata, epc, wdata_sel;
  logic        ie, exl;
  logic [7:0]  im, ip;

  // bubbles arrive as all-zero, so a zero link address means no instruction
  assign present = |WB_opcplus4;
  assign link    = WB_Jal | WB_Jalr | WB_Bgezal | WB_Bltzal;
  assign link31  = WB_Jal | WB_Bgezal | WB_Bltzal;
  assign irq     = present & ie & ~exl & |(ip & im);

  always_comb begin
    exc_take = 1'b1;
    exc_code = EXC_INT;
    if (irq)                          exc_code = EXC_INT;
    else if (WB_Reserved_instruction) exc_code = EXC_RI;
    else if (WB_Overflow)             exc_code = EXC_OV;
    else if (WB_Divide_zero)          exc_code = EXC_DZ;
    else if (WB_Syscall)              exc_code = EXC_SYS;
    else if (WB_Break)                exc_code = EXC_BP;
    else                              exc_take = 1'b0;
  end

  assign eret_take = WB_Eret & present & ~exc_take;
  assign mtc0_we   = WB_Mtc0 & present & ~exc_take;

  always_comb begin
    wdata_sel = WB_ALU_Result;
    if (WB_Mfc0)            wdata_sel = cp0_rdata;
    else if (WB_Mfhi)       wdata_sel = hi_q;
    else if (WB_Mflo)       wdata_sel = lo_q;
    else if (link)          wdata_sel = WB_opcplus4;
    else if (WB_MemIOtoReg) wdata_sel = WB_MemorIOData;
  end

  cp0_regs u_cp0 (
    .clock     (clock),
    .reset     (reset),
    .mtc0_we   (mtc0_we),
    .mtc0_addr (WB_rd),
    .mtc0_data (WB_rt_value),
    .raddr     (WB_rd),
    .rdata     (cp0_rdata),
    .exc_take  (exc_take),
    .exc_code  (exc_code),
    .exc_pc    (WB_PC),
    .eret_take (eret_take),
    .int_i     (int_i),
    .epc       (epc),
    .ie        (ie),
    .exl       (exl),
    .im        (im),
    .ip        (ip)
  );

  // mdu result belongs to the younger instruction, so it beats mthi/mtlo
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!exc_take) begin
      if (mdu_we) begin
        hi_q <= mdu_hi;
        lo_q <= mdu_lo;
      end else begin
        if (WB_Mthi) hi_q <= WB_ALU_Result;
        if (WB_Mtlo) lo_q <= WB_ALU_Result;
      end
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign rf_we       = ~reset & (WB_RegWrite | link) & present & ~exc_take;
  assign rf_waddr    = reset ? 5'd0 : (link31 ? 5'd31 : WB_waddr);
  assign rf_wdata    = reset ? 32'd0 : wdata_sel;
  assign flush       = ~reset & (exc_take | eret_take);
  assign redirect    = flush;
  assign redirect_pc = reset     ? 32'd0 :
                       exc_take  ? EXC_VECTOR :
                       eret_take ? epc : 32'd0;

endmodule

// File: tb/tb_wb_cp0_unit.sv
module tb_wb_cp0_unit;

  localparam logic [31:0] VEC = 32'h0000_F000;

  logic clock, reset;
  logic WB_RegWrite, WB_MemIOtoReg, WB_Mfhi, WB_Mflo, WB_Mthi, WB_Mtlo;
  logic WB_Jal, WB_Jalr, WB_Bgezal, WB_Bltzal, WB_Mfc0, WB_Mtc0, WB_Eret;
  logic WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break, WB_Reserved_instruction;
  logic [31:0] WB_opcplus4, WB_PC, WB_ALU_Result, WB_MemorIOData, WB_rt_value;
  logic [4:0]  WB_rd, WB_waddr;
  logic        mdu_we;
  logic [31:0] mdu_hi, mdu_lo;
  logic [5:0]  int_i;
  logic        rf_we, flush, redirect;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_o, lo_o, redirect_pc;

  wb_cp0_unit #(.EXC_VECTOR(VEC)) dut (
    .clock(clock), .reset(reset),
    .WB_RegWrite(WB_RegWrite), .WB_MemIOtoReg(WB_MemIOtoReg), .WB_Mfhi(WB_Mfhi),
    .WB_Mflo(WB_Mflo), .WB_Mthi(WB_Mthi), .WB_Mtlo(WB_Mtlo), .WB_Jal(WB_Jal),
    .WB_Jalr(WB_Jalr), .WB_Bgezal(WB_Bgezal), .WB_Bltzal(WB_Bltzal), .WB_Mfc0(WB_Mfc0),
    .WB_Mtc0(WB_Mtc0), .WB_Eret(WB_Eret), .WB_Overflow(WB_Overflow),
    .WB_Divide_zero(WB_Divide_zero), .WB_Syscall(WB_Syscall), .WB_Break(WB_Break),
    .WB_Reserved_instruction(WB_Reserved_instruction), .WB_opcplus4(WB_opcplus4),
    .WB_PC(WB_PC), .WB_ALU_Result(WB_ALU_Result), .WB_MemorIOData(WB_MemorIOData),
    .WB_rt_value(WB_rt_value), .WB_rd(WB_rd), .WB_waddr(WB_waddr), .mdu_we(mdu_we),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .int_i(int_i), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .hi_o(hi_o), .lo_o(lo_o), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rf_we;
    logic        chk_data;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic        redirect;
    logic        chk_pc;
    logic [31:0] rpc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference CP0 / HI-LO state
  logic [31:0] m_hi, m_lo, m_count, m_compare, m_epc;
  logic        m_ie, m_exl, m_tp;
  logic [7:0]  m_im, m_ip;
  logic [4:0]  m_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_cp0(input logic [4:0] rd);
    case (rd)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {16'h0, m_ip, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_zero();
    m_hi = 0; m_lo = 0; m_count = 0; m_compare = 0; m_epc = 0;
    m_ie = 0; m_exl = 0; m_tp = 0; m_im = 0; m_ip = 0; m_code = 0;
  endtask

  task automatic clear_inputs();
    {WB_RegWrite, WB_MemIOtoReg, WB_Mfhi, WB_Mflo, WB_Mthi, WB_Mtlo} = '0;
    {WB_Jal, WB_Jalr, WB_Bgezal, WB_Bltzal, WB_Mfc0, WB_Mtc0, WB_Eret} = '0;
    {WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break, WB_Reserved_instruction} = '0;
    WB_opcplus4 = 0; WB_PC = 0; WB_ALU_Result = 0; WB_MemorIOData = 0; WB_rt_value = 0;
    WB_rd = 0; WB_waddr = 0; mdu_we = 0; mdu_hi = 0; mdu_lo = 0; int_i = 0;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    WB_PC = pc;
    WB_opcplus4 = pc + 32'd4;
  endtask

  // Predict this cycle's outputs, queue them, advance the model across the edge.
  task automatic step();
    exp_t e;
    logic present, link, irq, exc, wr, match;
    logic [4:0] code;
    present = (WB_opcplus4 != 0);
    link = WB_Jal | WB_Jalr | WB_Bgezal | WB_Bltzal;
    irq = present && m_ie && !m_exl && ((m_ip & m_im) != 0);
    exc = irq | WB_Reserved_instruction | WB_Overflow | WB_Divide_zero | WB_Syscall | WB_Break;
    code = irq ? 5'd0 : WB_Reserved_instruction ? 5'd10 : WB_Overflow ? 5'd12 :
           WB_Divide_zero ? 5'd13 : WB_Syscall ? 5'd8 : 5'd9;
    e = '0;
    e.hi = m_hi;
    e.lo = m_lo;
    e.chk_data = reset;
    e.chk_pc = reset;
    if (!reset) begin
      e.rf_we = (WB_RegWrite | link) & present & !exc;
      e.waddr = (WB_Jal | WB_Bgezal | WB_Bltzal) ? 5'd31 : WB_waddr;
      e.wdata = WB_Mfc0 ? m_cp0(WB_rd) : WB_Mfhi ? m_hi : WB_Mflo ? m_lo :
                link ? WB_opcplus4 : WB_MemIOtoReg ? WB_MemorIOData : WB_ALU_Result;
      e.flush = exc | (WB_Eret & present);
      e.redirect = e.flush;
      e.rpc = exc ? VEC : m_epc;
      e.chk_data = e.rf_we;
      e.chk_pc = e.redirect;
    end
    q.push_back(e);
    if (reset) model_zero();
    else begin
      match = (m_count == m_compare) && (m_compare != 0);
      m_ip[7:2] = {int_i[5] | m_tp | match, int_i[4:0]};
      m_tp = m_tp | match;
      m_count = m_count + 1;
      if (!exc) begin
        if (mdu_we) begin m_hi = mdu_hi; m_lo = mdu_lo; end
        else begin
          if (WB_Mthi) m_hi = WB_ALU_Result;
          if (WB_Mtlo) m_lo = WB_ALU_Result;
        end
      end
      wr = WB_Mtc0 & present & !exc;
      if (wr) case (WB_rd)
        5'd9:  m_count = WB_rt_value;
        5'd11: begin m_compare = WB_rt_value; m_tp = 0; end
        5'd12: begin m_ie = WB_rt_value[0]; m_exl = WB_rt_value[1]; m_im = WB_rt_value[15:8]; end
        5'd13: m_ip[1:0] = WB_rt_value[9:8];
        5'd14: m_epc = WB_rt_value;
        default: ;
      endcase
      if (exc) begin
        if (!m_exl) m_epc = WB_PC;
        m_exl = 1;
        m_code = code;
      end else if (WB_Eret & present) m_exl = 0;
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rf_we", {31'h0, rf_we}, {31'h0, e.rf_we});
      chk("flush", {31'h0, flush}, {31'h0, e.flush});
      chk("redirect", {31'h0, redirect}, {31'h0, e.redirect});
      chk("hi_o", hi_o, e.hi);
      chk("lo_o", lo_o, e.lo);
      if (e.chk_data) begin
        chk("rf_waddr", {27'h0, rf_waddr}, {27'h0, e.waddr});
        chk("rf_wdata", rf_wdata, e.wdata);
      end
      if (e.chk_pc) chk("redirect_pc", redirect_pc, e.rpc);
    end
  end

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 5))
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_instr();
    int k;
    clear_inputs();
    k = $urandom_range(0, 19);
    set_pc($urandom & 32'h7FFF_FFFC);
    WB_ALU_Result = $urandom; WB_MemorIOData = $urandom; WB_rt_value = $urandom;
    WB_waddr = 5'($urandom); WB_rd = pick_rd();
    mdu_we = ($urandom_range(0, 3) == 0);
    mdu_hi = $urandom; mdu_lo = $urandom;
    int_i = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
    case (k)
      0, 1: begin
        WB_opcplus4 = 0; WB_PC = 0; WB_ALU_Result = 0; WB_MemorIOData = 0;
        WB_rt_value = 0; WB_rd = 0; WB_waddr = 0;
      end
      2:  WB_RegWrite = 1;
      3:  begin WB_RegWrite = 1; WB_MemIOtoReg = 1; end
      4:  WB_Jal = 1;
      5:  begin WB_Jalr = 1; WB_RegWrite = 1; end
      6:  WB_Bgezal = 1;
      7:  WB_Bltzal = 1;
      8:  begin WB_Mfhi = 1; WB_RegWrite = 1; end
      9:  begin WB_Mflo = 1; WB_RegWrite = 1; end
      10: WB_Mthi = 1;
      11: WB_Mtlo = 1;
      12: begin WB_Mfc0 = 1; WB_RegWrite = 1; end
      13, 14: WB_Mtc0 = 1;
      15: WB_Eret = 1;
      16: WB_Syscall = 1;
      17: WB_Break = 1;
      18: WB_Reserved_instruction = 1;
      default: begin
        WB_RegWrite = 1;
        if ($urandom_range(0, 1) == 0) WB_Overflow = 1; else WB_Divide_zero = 1;
      end
    endcase
  endtask

  task automatic mfc0(input logic [4:0] rd, input logic [31:0] pc);
    clear_inputs(); set_pc(pc); WB_Mfc0 = 1; WB_RegWrite = 1; WB_rd = rd; WB_waddr = 5'd2;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] val);
    clear_inputs(); set_pc(32'h80); WB_Mtc0 = 1; WB_rd = rd; WB_rt_value = val;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clock); #1;
    model_zero();
    // exceptions and writes raised during reset must be ignored
    repeat (3) begin
      rand_instr(); WB_Overflow = 1; int_i = 6'h3F;
      step();
    end
    reset = 0;
    clear_inputs();

    // load
    set_pc(32'h0); WB_RegWrite = 1; WB_MemIOtoReg = 1; WB_waddr = 5'd5;
    WB_MemorIOData = 32'hDEADBEEF;
    #1;
    chk("load_we", {31'h0, rf_we}, 32'h1);
    chk("load_waddr", {27'h0, rf_waddr}, 32'd5);
    chk("load_wdata", rf_wdata, 32'hDEADBEEF);
    step();

    // jal link
    clear_inputs(); WB_Jal = 1; WB_opcplus4 = 32'h104; WB_PC = 32'h100; WB_waddr = 5'd7;
    #1;
    chk("jal_waddr", {27'h0, rf_waddr}, 32'd31);
    chk("jal_wdata", rf_wdata, 32'h104);
    step();

    // mthi then mfhi, then mthi racing an mdu write
    clear_inputs(); set_pc(32'h108); WB_Mthi = 1; WB_ALU_Result = 32'h1234;
    step();
    clear_inputs(); set_pc(32'h10C); WB_Mfhi = 1; WB_RegWrite = 1; WB_waddr = 5'd3;
    #1;
    chk("mfhi_wdata", rf_wdata, 32'h1234);
    step();
    clear_inputs(); set_pc(32'h110); WB_Mthi = 1; WB_ALU_Result = 32'h777;
    mdu_we = 1; mdu_hi = 32'h55; mdu_lo = 32'h66;
    step();
    clear_inputs();
    chk("mdu_wins_hi", hi_o, 32'h55);
    chk("mdu_lo", lo_o, 32'h66);

    // overflow
    set_pc(32'h200); WB_RegWrite = 1; WB_Overflow = 1; WB_waddr = 5'd4;
    #1;
    chk("ov_flush", {31'h0, flush}, 32'h1);
    chk("ov_rf_we", {31'h0, rf_we}, 32'h0);
    chk("ov_rpc", redirect_pc, VEC);
    step();
    mfc0(5'd14, 32'hF000); #1; chk("ov_epc", rf_wdata, 32'h200); step();
    mfc0(5'd13, 32'hF004); #1; chk("ov_cause", rf_wdata, 32'h30); step();
    mfc0(5'd12, 32'hF008); #1; chk("ov_status", rf_wdata, 32'h2); step();

    // nested syscall keeps EPC; eret returns to it
    clear_inputs(); set_pc(32'h300); WB_Syscall = 1;
    #1; chk("sys_redirect", {31'h0, redirect}, 32'h1);
    step();
    mfc0(5'd14, 32'hF00C); #1; chk("nested_epc", rf_wdata, 32'h200); step();
    clear_inputs(); set_pc(32'hF010); WB_Eret = 1;
    #1; chk("eret_rpc", redirect_pc, 32'h200);
    step();
    mfc0(5'd12, 32'h204); #1; chk("eret_status", rf_wdata, 32'h0); step();

    // timer interrupt
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd10);
    mtc0(5'd12, 32'h8001);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      #1; chk("bubble_no_irq", {31'h0, flush}, 32'h0);
      step();
    end
    clear_inputs(); set_pc(32'h400); WB_RegWrite = 1; WB_waddr = 5'd9;
    #1;
    chk("timer_flush", {31'h0, flush}, 32'h1);
    chk("timer_rf_we", {31'h0, rf_we}, 32'h0);
    chk("timer_rpc", redirect_pc, VEC);
    step();
    mfc0(5'd14, 32'hF000); #1; chk("timer_epc", rf_wdata, 32'h400); step();
    mfc0(5'd13, 32'hF004); #1; chk("timer_cause", rf_wdata, 32'h8000); step();
    mtc0(5'd11, 32'd0);
    clear_inputs(); set_pc(32'hF008); WB_Eret = 1; step();

    // count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    mfc0(5'd9, 32'h500); #1; chk("count_max", rf_wdata, 32'hFFFF_FFFF); step();
    mfc0(5'd9, 32'h504); #1; chk("count_wrap", rf_wdata, 32'h0); step();

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin rand_instr(); step(); end
    reset = 1;
    repeat (2) begin
      rand_instr(); WB_Overflow = 1;
      step();
    end
    reset = 0;
    for (int i = 0; i < 1500; i++) begin rand_instr(); step(); end

    clear_inputs();
    repeat (2) @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
